// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the LC-3b memory side.
//   lc3b_word     16-bit byte address / data word
//   lc3b_c_block  128-bit cache line
//   pmem_state_t  pmem_responder FSM state (IDLE, BUSY, RESP)
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_block;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } pmem_state_t;

endpackage

// File: rtl/pmem_array.sv
// pmem_array: line storage for pmem_responder. No reset, so contents
// survive a responder reset.
//   clk_i    clock
//   we_i     write enable (line committed on rising edge)
//   waddr_i  write line index
//   wdata_i  write line data
//   raddr_i  read line index
//   rdata_o  read line data (combinational)
module pmem_array
    import lc3b_types::*;
#(
    parameter int INDEX_BITS = 12
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] waddr_i,
    input  lc3b_c_block           wdata_i,
    input  logic [INDEX_BITS-1:0] raddr_i,
    output lc3b_c_block           rdata_o
);

    lc3b_c_block mem_q [2**INDEX_BITS];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency physical memory model answering line
// read/write requests with a one-cycle pmem_resp pulse LATENCY cycles
// after the request is accepted.
//   clk, reset    clock, asynchronous active-high reset
//   pmem_address  byte address; line index = pmem_address[INDEX_BITS+3:4]
//   pmem_read     line read request (held until pmem_resp)
//   pmem_write    line write request (held until pmem_resp); wins over read
//   pmem_wdata    write line data
//   pmem_resp     one-cycle completion pulse
//   pmem_rdata    line returned by the most recent completed read
//   pmem_error    sticky protocol-violation flag
// Optional feature macro: PMEM_PROTOCOL_CHECK_EN enables pmem_error
// (simultaneous read+write at acceptance, request dropped or address
// changed while BUSY). Without it pmem_error is tied 0.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  lc3b_word    pmem_address,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  lc3b_c_block pmem_wdata,
    output logic        pmem_resp,
    output lc3b_c_block pmem_rdata,
    output logic        pmem_error
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    pmem_state_t           state_q;
    logic [3:0]            cnt_q;
    logic [INDEX_BITS-1:0] idx_q;
    lc3b_c_block           wdata_q;
    logic                  wr_q;
    logic                  resp_q;
    lc3b_c_block           rdata_q;

    logic [INDEX_BITS-1:0] idx_in;
    logic [INDEX_BITS-1:0] rd_idx;
    lc3b_c_block           arr_rdata;
    logic                  unused_addr_bits;

    assign idx_in           = pmem_address[INDEX_BITS+3:4];
    assign unused_addr_bits = ^pmem_address[3:0];

    // In IDLE the array is looked up with the incoming address so a
    // LATENCY=1 read can capture its line on the acceptance edge.
    assign rd_idx = (state_q == IDLE) ? idx_in : idx_q;

    pmem_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk_i   (clk),
        .we_i    ((state_q == RESP) && wr_q),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        idx_q   <= idx_in;
                        wdata_q <= pmem_wdata;
                        wr_q    <= pmem_write;
                        cnt_q   <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            if (!pmem_write) rdata_q <= arr_rdata;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    // Counter hits 0 on this edge: next cycle is RESP.
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        if (!wr_q) rdata_q <= arr_rdata;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem_resp  = resp_q;
    assign pmem_rdata = rdata_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE && pmem_read && pmem_write) ||
                     (state_q == BUSY &&
                      ((wr_q ? !pmem_write : !pmem_read) || (idx_in != idx_q)))) begin
            err_q <= 1'b1;
        end
    end

    assign pmem_error = err_q;
`else
    assign pmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;
    import lc3b_types::*;

`ifdef PMEM_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D3 = 128'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_1234_5678;
    localparam logic [127:0] D4 = 128'hCAFE_F00D_0BAD_BEEF_1357_9BDF_2468_ACE0;
    localparam logic [127:0] D5 = 128'h5555_0000_5555_0000_5555_0000_5555_0202;
    localparam logic [127:0] D6 = 128'h3333_0000_3333_0000_3333_0000_3333_0303;
    localparam logic [127:0] D7 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_0040;
    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] JUNK = {8{16'hBAD0}};

    logic        clk = 1'b0;
    logic        reset;
    lc3b_word    pmem_address;
    logic        pmem_read, pmem_write;
    lc3b_c_block pmem_wdata, pmem_rdata;
    logic        pmem_resp, pmem_error;

    lc3b_word    a1;
    logic        r1, w1;
    lc3b_c_block wd1, rdata1;
    logic        resp1, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(4), .INDEX_BITS(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .pmem_error   (pmem_error)
    );

    // Small array so address wrap can be exercised.
    pmem_responder #(.LATENCY(1), .INDEX_BITS(4)) dut_l1 (
        .clk          (clk),
        .reset        (reset),
        .pmem_address (a1),
        .pmem_read    (r1),
        .pmem_write   (w1),
        .pmem_wdata   (wd1),
        .pmem_resp    (resp1),
        .pmem_rdata   (rdata1),
        .pmem_error   (err1)
    );

    typedef struct {
        logic           rd;
        logic           wr;
        logic [15:0]    addr;
        logic [127:0]   wd;
        logic [127:0]   exp_rdata;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Main DUT transaction: returns cycles from acceptance to pmem_resp
    // (0 cycles budget exceeded => lat reported as 40) and rdata then.
    task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [127:0] wd, output int lat, output logic [127:0] rdo);
        @(negedge clk);
        pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = wd;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!pmem_resp && lat < 40);
        rdo = pmem_rdata;
        pmem_read = 1'b0; pmem_write = 1'b0;
    endtask

    task automatic txn1(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [127:0] wd, output int lat, output logic [127:0] rdo);
        @(negedge clk);
        r1 = rd; w1 = wr; a1 = a; wd1 = wd;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp1 && lat < 40);
        rdo = rdata1;
        r1 = 1'b0; w1 = 1'b0;
    endtask

    initial begin
        int lat;
        int t0, t1, npulse;
        logic seen;
        logic [127:0] rd;

        tbl[0] = '{1'b0, 1'b1, 16'h1230, D1, 128'h0};
        tbl[1] = '{1'b1, 1'b0, 16'h123E, 128'h0, D1};
        tbl[2] = '{1'b0, 1'b1, 16'h0100, D2, D1};
        tbl[3] = '{1'b0, 1'b1, 16'hFFF0, D3, D1};
        tbl[4] = '{1'b1, 1'b0, 16'h0100, 128'h0, D2};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 128'h0, D3};
        tbl[6] = '{1'b0, 1'b1, 16'h0100, D4, D3};
        tbl[7] = '{1'b1, 1'b0, 16'h010F, 128'h0, D4};
        tbl[8] = '{1'b1, 1'b0, 16'h1230, 128'h0, D1};

        reset = 1'b1;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; wd1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_resp", {127'b0, pmem_resp}, 128'd0);
        chk("reset_rdata", pmem_rdata, 128'd0);
        chk("reset_err", {127'b0, pmem_error}, 128'd0);
        reset = 1'b0;

        // Table-driven transactions, LATENCY=4
        for (int i = 0; i < 9; i++) begin
            txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, lat, rd);
            chk($sformatf("row%0d_latency", i), 128'(lat), 128'd4);
            chk($sformatf("row%0d_rdata", i), rd, tbl[i].exp_rdata);
            @(negedge clk);
            chk($sformatf("row%0d_resp_width", i), {127'b0, pmem_resp}, 128'd0);
        end
        chk("legal_traffic_err", {127'b0, pmem_error}, 128'd0);

        // Read+write together: write only, rdata untouched
        txn(1'b1, 1'b1, 16'h2000, DA5, lat, rd);
        chk("rw_latency", 128'(lat), 128'd4);
        chk("rw_rdata_held", rd, D1);
        txn(1'b1, 1'b0, 16'h2000, 128'h0, lat, rd);
        chk("rw_readback", rd, DA5);
        chk("rw_err", {127'b0, pmem_error}, {127'b0, EXP_ERR});

        // Reset 2 cycles after acceptance of a read
        @(negedge clk);
        pmem_read = 1'b1; pmem_address = 16'h0100;
        repeat (2) @(negedge clk);
        reset = 1'b1; pmem_read = 1'b0;
        #1;
        chk("abort_resp", {127'b0, pmem_resp}, 128'd0);
        chk("abort_rdata", pmem_rdata, 128'd0);
        chk("abort_err", {127'b0, pmem_error}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (pmem_resp) seen = 1'b1; end
        chk("abort_no_resp", {127'b0, seen}, 128'd0);

        // Reset during the RESP cycle of a write: no commit
        @(negedge clk);
        pmem_write = 1'b1; pmem_address = 16'h0100; pmem_wdata = JUNK;
        repeat (4) @(negedge clk);
        reset = 1'b1; pmem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        txn(1'b1, 1'b0, 16'h0100, 128'h0, lat, rd);
        chk("abort_contents", rd, D4);

        // Read held through RESP: pulses LATENCY+1 apart
        @(negedge clk);
        pmem_read = 1'b1; pmem_address = 16'h1230;
        t0 = -1; t1 = -1; npulse = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                if (npulse == 0) t0 = k;
                else if (npulse == 1) t1 = k;
                npulse++;
            end
        end
        pmem_read = 1'b0;
        chk("held_first", 128'(t0), 128'd4);
        chk("held_spacing", 128'(t1 - t0), 128'd5);
        chk("held_rdata", pmem_rdata, D1);
        repeat (2) @(negedge clk);

        // Address switched during BUSY
        txn(1'b0, 1'b1, 16'h0200, D5, lat, rd);
        txn(1'b0, 1'b1, 16'h0300, D6, lat, rd);
        chk("pre_switch_err", {127'b0, pmem_error}, 128'd0);
        @(negedge clk);
        pmem_read = 1'b1; pmem_address = 16'h0200;
        @(negedge clk);
        lat = 1;
        pmem_address = 16'h0300;
        while (!pmem_resp && lat < 40) begin @(negedge clk); lat++; end
        pmem_read = 1'b0;
        chk("switch_latency", 128'(lat), 128'd4);
        chk("switch_rdata", pmem_rdata, D5);
        chk("switch_err", {127'b0, pmem_error}, {127'b0, EXP_ERR});

        // LATENCY=1 instance, 16-line array
        txn1(1'b0, 1'b1, 16'h0040, D7, lat, rd);
        chk("l1_wr_latency", 128'(lat), 128'd1);
        @(negedge clk);
        chk("l1_wr_resp_width", {127'b0, resp1}, 128'd0);
        txn1(1'b1, 1'b0, 16'h0040, 128'h0, lat, rd);
        chk("l1_rd_latency", 128'(lat), 128'd1);
        chk("l1_rd_rdata", rd, D7);
        @(negedge clk);
        chk("l1_rd_resp_width", {127'b0, resp1}, 128'd0);
        txn1(1'b1, 1'b0, 16'h0140, 128'h0, lat, rd);
        chk("l1_wrap_rdata", rd, D7);
        chk("l1_err", {127'b0, err1}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to pmem_resp (legal 1..15).
REQ-002 SHALL have parameter INDEX_BITS, default 12, meaning number of line-index bits (2^INDEX_BITS lines of 128 bits).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port pmem_address, input, 16 (lc3b_word), byte address; line index = pmem_address[INDEX_BITS+3:4], bits [3:0] ignored.
REQ-006 SHALL have port pmem_read, input, 1, line read request, held high until pmem_resp.
REQ-007 SHALL have port pmem_write, input, 1, line write request, held high until pmem_resp.
REQ-008 SHALL have port pmem_wdata, input, 128 (lc3b_c_block), write line data.
REQ-009 SHALL have port pmem_resp, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port pmem_rdata, output, 128 (lc3b_c_block), read line data.
REQ-011 SHALL have port pmem_error, output, 1, sticky protocol-violation flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-013 IDLE: on an edge with pmem_read or pmem_write high, SHALL latch address, wdata and op, load counter with LATENCY-1, go to BUSY (or directly to RESP if LATENCY=1).
REQ-014 BUSY: SHALL decrement counter each cycle; when it reaches 0, go to RESP on the next edge.
REQ-015 pmem_resp SHALL be high for exactly one cycle, the LATENCY-th cycle after the acceptance edge, only in RESP.
REQ-016 RESP: SHALL return to IDLE unconditionally; no new request is accepted during RESP, so back-to-back requests are separated by at least one IDLE cycle.
REQ-017 Read: pmem_rdata SHALL present the addressed line during the RESP cycle and hold it until the next read's RESP.
REQ-018 Write: the latched line SHALL be committed on the edge ending RESP; a read to the same line accepted afterward returns the new data.
REQ-019 Simultaneous pmem_read and pmem_write at acceptance: SHALL perform the write only.
REQ-020 Request inputs changing or dropping during BUSY SHALL be ignored; the latched transaction completes and pmem_resp still pulses.
REQ-021 The address SHALL wrap modulo 2^INDEX_BITS lines; upper bits beyond the index are ignored.

Reset
REQ-022 reset SHALL force state IDLE, counter 0, pmem_resp 0, pmem_rdata 0, pmem_error 0, asynchronously.
REQ-023 reset mid-transaction SHALL abort it: no pmem_resp, no write commit.
REQ-024 Line storage SHALL NOT be cleared by reset.

Configuration
REQ-025 Macro PMEM_PROTOCOL_CHECK_EN defined: pmem_error SHALL set, and stay set until reset, on simultaneous read+write at acceptance, on request dropped during BUSY, or on address change during BUSY.
REQ-026 Macro absent: pmem_error SHALL be tied 0 and no checking logic exists.

Structure
REQ-027 lc3b_types SHALL hold lc3b_word, lc3b_c_block and a new pmem_state_t enum (IDLE, BUSY, RESP).
REQ-028 Line storage SHALL be a sub-module pmem_array: one synchronous write port, one combinational read port, INDEX_BITS parameter.

Verification
REQ-029 Write 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 0x1230, then read 0x123E -> pmem_resp pulses 4 cycles after each acceptance; rdata equals written line.
REQ-030 LATENCY=1, read 0x0040 -> pmem_resp high in the cycle right after acceptance, one cycle wide.
REQ-031 Read asserted with write at 0x2000, data all 0xA5 -> write performed; read of 0x2000 returns 0xA5..A5; pmem_error=1 with macro, 0 without.
REQ-032 Read 0x0100 and assert reset 2 cycles after acceptance -> no pmem_resp; outputs 0; prior contents of 0x0100 intact on re-read.
REQ-033 Read held high through RESP and beyond -> second acceptance only after one IDLE cycle; resp pulses separated by LATENCY+1 cycles.
REQ-034 Address switched 0x0200->0x0300 during BUSY of a read -> returned line is that of 0x0200; pmem_error=1 with macro.
